// File: rtl/seven_seg_scan_ctrl_pkg.sv
// seven_seg_pkg: shared types and constants for the seven-segment scan controller
// Contents: state_t        scan FSM states
//           SEG_ALL_OFF    active-low segment pattern with every segment dark
//           AN_ALL_OFF     active-low anode pattern with every digit dark (slice to NUM_DIGITS)
//           nibble_at()    extracts nibble i from a packed display word
package seven_seg_pkg;

    typedef enum logic {
        S_BLANK,
        S_DRIVE
    } state_t;

    localparam int MAX_DIGITS = 8;
    localparam logic [6:0] SEG_ALL_OFF = 7'h7F;
    localparam logic [MAX_DIGITS-1:0] AN_ALL_OFF = '1;

    // Callers zero-extend their display word to the widest supported size.
    function automatic logic [3:0] nibble_at(input logic [4*MAX_DIGITS-1:0] v, input logic [2:0] i);
        return v[{i, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// seven_seg_scan_ctrl_if: one-entry valid/ready load port for new display values
// Signals: load_valid  producer presents load_data
//          load_ready  controller can take a value (pending buffer empty)
//          load_data   nibble i (bits 4i+3:4i) is shown on digit i
// Modports: master = producer, slave = scan controller
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);

    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );

endinterface

// File: rtl/seven_seg_scan_ctrl_timer.sv
// seg_scan_timer: slot prescaler and digit index for the scan controller
// Ports: i_clk, i_rst_n    clock, asynchronous active-low reset
//        i_enable          0 holds the scan at digit 0, slot start
//        o_idx             digit index of the current slot
//        o_idx_next        digit index the next cycle will have
//        o_slot_end        this cycle is the last of its slot
//        o_frame_end       this cycle is the last of the last digit's slot
//        o_in_blank        the next cycle falls inside the blanking window
module seg_scan_timer #(
    parameter int  NUM_DIGITS   = 4,
    parameter int  DIGIT_CYCLES = 100000,
    parameter int  BLANK_CYCLES = 1000,
    localparam int CW           = $clog2(DIGIT_CYCLES),
    localparam int IW           = $clog2(NUM_DIGITS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_enable,
    output logic [IW-1:0] o_idx,
    output logic [IW-1:0] o_idx_next,
    output logic          o_slot_end,
    output logic          o_frame_end,
    output logic          o_in_blank
);

    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_idx;

    always_comb begin
        o_idx       = r_idx;
        o_slot_end  = i_enable && r_cnt == CW'(DIGIT_CYCLES - 1);
        o_frame_end = o_slot_end && r_idx == IW'(NUM_DIGITS - 1);
        // Looking one cycle ahead lets the FSM and anodes change on the same
        // edge that the count crosses into or out of the blanking window.
        o_in_blank  = !(i_enable && !o_slot_end && r_cnt >= CW'(BLANK_CYCLES - 1));
        o_idx_next  = (!i_enable || o_frame_end) ? '0 : o_slot_end ? r_idx + IW'(1) : r_idx;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= (!i_enable || o_slot_end) ? '0 : r_cnt + CW'(1);
            r_idx <= o_idx_next;
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexes a shared hex-to-7-segment decoder over common-anode digits
// Ports: i_clk, i_rst_n    clock, asynchronous active-low reset
//        i_enable          1 = scanning, 0 = dark and held at digit 0
//        load_if           valid/ready load port (slave); values commit at frame boundaries
//        i_blank_mask      bit i = 1 keeps digit i dark
//        o_digit_num       nibble presented to the external decoder
//        i_seg_in          decoder output {a..g}, active-low
//        o_seg_out         registered segment pins, active-low
//        o_an_out          registered anode enables, active-low
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int  NUM_DIGITS   = 4,
    parameter int  DIGIT_CYCLES = 100000,
    parameter int  BLANK_CYCLES = 1000,
    localparam int IW           = $clog2(NUM_DIGITS),
    localparam int DW           = 4 * NUM_DIGITS
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    seven_seg_scan_ctrl_if.slave    load_if,
    input  logic [NUM_DIGITS-1:0]   i_blank_mask,
    output logic [3:0]              o_digit_num,
    input  logic [6:0]              i_seg_in,
    output logic [6:0]              o_seg_out,
    output logic [NUM_DIGITS-1:0]   o_an_out
);

    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ALL_OFF[NUM_DIGITS-1:0];
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    logic [IW-1:0]         w_idx;
    logic [IW-1:0]         w_idx_next;
    logic                  w_slot_end;
    logic                  w_frame_end;
    logic                  w_in_blank;
    logic                  w_fire;
    logic                  w_commit;
    logic                  w_drive;
    logic [DW-1:0]         w_disp_next;
    logic [NUM_DIGITS-1:0] w_an_next;

    state_t                r_state;
    logic [DW-1:0]         r_disp;
    logic [DW-1:0]         r_pend_data;
    logic                  r_pend;
    logic [3:0]            r_digit;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    seg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_enable     (i_enable),
        .o_idx        (w_idx),
        .o_idx_next   (w_idx_next),
        .o_slot_end   (w_slot_end),
        .o_frame_end  (w_frame_end),
        .o_in_blank   (w_in_blank)
    );

    always_comb begin
        w_fire      = load_if.load_valid && !r_pend;
        // While disabled nothing is on screen, so every cycle is a safe commit point.
        w_commit    = w_frame_end || !i_enable;
        // A load arriving on a commit cycle with nothing pending bypasses the buffer.
        w_disp_next = !w_commit ? r_disp : r_pend ? r_pend_data : w_fire ? load_if.load_data : r_disp;
        w_drive     = r_state == S_BLANK ? !w_in_blank : (i_enable && !w_slot_end);
        w_an_next   = (w_drive && !i_blank_mask[w_idx]) ? ~(AN_ONE << w_idx) : AN_OFF;
    end

    assign load_if.load_ready = !r_pend;
    assign o_digit_num        = r_digit;
    assign o_seg_out          = r_seg;
    assign o_an_out           = r_an;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_BLANK;
            r_an    <= AN_OFF;
            r_seg   <= SEG_ALL_OFF;
        end else begin
            case (r_state)
                S_BLANK: if (!w_in_blank) r_state <= S_DRIVE;
                default: if (!i_enable || w_slot_end) r_state <= S_BLANK;
            endcase
            r_an  <= w_an_next;
            // Dark segments whenever no anode is on, so stale decoder output never leaks.
            r_seg <= (w_an_next == AN_OFF) ? SEG_ALL_OFF : i_seg_in;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_disp      <= '0;
            r_pend_data <= '0;
            r_pend      <= 1'b0;
            r_digit     <= '0;
        end else begin
            r_disp <= w_disp_next;
            if (w_commit) begin
                r_pend <= 1'b0;
            end else if (w_fire) begin
                r_pend      <= 1'b1;
                r_pend_data <= load_if.load_data;
            end
            // Track the next index and next display word so the decoder input is
            // already correct on the first cycle of every slot.
            r_digit <= nibble_at((4*MAX_DIGITS)'(w_disp_next), 3'(w_idx_next));
        end
    end

endmodule
